// File: rtl/pc_flow_ctrl_if.sv
// rtl/pc_flow_ctrl_if.sv - decode-side request and program_counter redirect bundle for pc_flow_ctrl
`timescale 1ns/1ps
interface pc_flow_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  logic [WIDTH-1:0]         pc_in;
  logic [WIDTH-1:0]         target;
  logic                     branch_req;
  logic                     cond_true;
  logic                     call_req;
  logic                     ret_req;
  logic                     stall_in;
  logic                     req_ready;
  logic                     jump_enable;
  logic [WIDTH-1:0]         jump_address;
  logic                     flush;
  logic                     fault;
  logic [$clog2(DEPTH):0]   ras_count;

  // decode stage side: drives requests, observes redirects
  modport master (
    output pc_in, target, branch_req, cond_true, call_req, ret_req, stall_in,
    input  req_ready, jump_enable, jump_address, flush, fault, ras_count
  );

  // sequencer side
  modport slave (
    input  pc_in, target, branch_req, cond_true, call_req, ret_req, stall_in,
    output req_ready, jump_enable, jump_address, flush, fault, ras_count
  );
endinterface

// File: rtl/pc_flow_ctrl.sv
// rtl/pc_flow_ctrl.sv - branch/call/return sequencer with return-address stack; optional PC_FLOW_RAS_WRAP_EN
`timescale 1ns/1ps
module pc_flow_ctrl #(
  parameter int               WIDTH        = 16,
  parameter int               DEPTH        = 8,
  parameter int               FLUSH_CYCLES = 2,
  parameter logic [WIDTH-1:0] FAULT_VECTOR = WIDTH'(16'hFFF0)
) (
  input logic            clk,
  input logic            reset,
  pc_flow_ctrl_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] S_RUN        = 3'd0;
  localparam logic [2:0] S_REDIRECT   = 3'd1;
  localparam logic [2:0] S_FLUSH      = 3'd2;
  localparam logic [2:0] S_FAULT_JUMP = 3'd3;
  localparam logic [2:0] S_FAULT_HOLD = 3'd4;

  // FLUSH counts down to zero, so it is loaded with one less than its length
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  logic [2:0]       state, state_n;
  logic [3:0]       flush_cnt, flush_cnt_n;
  logic [WIDTH-1:0] ras [DEPTH];
  logic [AW-1:0]    ptr;
  logic [AW-1:0]    top_idx;
  logic [CW-1:0]    count;
  logic             full, empty;
  logic             do_push, do_pop;
  logic [WIDTH-1:0] jaddr_n;
  logic             fault_n;

  logic             je_q, flush_q, rdy_q, fault_q;
  logic [WIDTH-1:0] ja_q;

  // ptr is the next free slot; the stack is indexed circularly so the
  // wrap build can overwrite the oldest entry without moving data
  assign top_idx = ptr - 1'b1;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

  assign bus.jump_enable  = je_q;
  assign bus.jump_address = ja_q;
  assign bus.flush        = flush_q;
  assign bus.req_ready    = rdy_q;
  assign bus.fault        = fault_q;
  assign bus.ras_count    = count;

  // next-state decode: request arbitration in RUN, fixed sequencing elsewhere
  always_comb begin
    state_n     = state;
    flush_cnt_n = flush_cnt;
    do_push     = 1'b0;
    do_pop      = 1'b0;
    jaddr_n     = ja_q;
    fault_n     = fault_q;
    case (state)
      S_RUN: begin
        if (!bus.stall_in) begin
          if (bus.ret_req) begin
            if (empty) begin
              fault_n = 1'b1;
              jaddr_n = FAULT_VECTOR;
              state_n = S_FAULT_JUMP;
            end else begin
              do_pop  = 1'b1;
              jaddr_n = ras[top_idx];
              state_n = S_REDIRECT;
            end
          end else if (bus.call_req) begin
`ifdef PC_FLOW_RAS_WRAP_EN
            do_push = 1'b1;
            jaddr_n = bus.target;
            state_n = S_REDIRECT;
`else
            if (full) begin
              fault_n = 1'b1;
              jaddr_n = FAULT_VECTOR;
              state_n = S_FAULT_JUMP;
            end else begin
              do_push = 1'b1;
              jaddr_n = bus.target;
              state_n = S_REDIRECT;
            end
`endif
          end else if (bus.branch_req && bus.cond_true) begin
            jaddr_n = bus.target;
            state_n = S_REDIRECT;
          end
        end
      end
      S_REDIRECT: begin
        if (FLUSH_CYCLES > 0) begin
          state_n     = S_FLUSH;
          flush_cnt_n = FLUSH_LOAD;
        end else begin
          state_n = S_RUN;
        end
      end
      S_FLUSH: begin
        if (flush_cnt == 4'd0) state_n = S_RUN;
        else flush_cnt_n = flush_cnt - 4'd1;
      end
      S_FAULT_JUMP: state_n = S_FAULT_HOLD;
      S_FAULT_HOLD: state_n = S_FAULT_HOLD;
      default:      state_n = S_RUN;
    endcase
  end

  // state, stack bookkeeping and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_RUN;
      flush_cnt <= 4'd0;
      ptr       <= '0;
      count     <= '0;
      je_q      <= 1'b0;
      ja_q      <= '0;
      flush_q   <= 1'b0;
      rdy_q     <= 1'b1;
      fault_q   <= 1'b0;
    end else begin
      state     <= state_n;
      flush_cnt <= flush_cnt_n;
      if (do_push) begin
        ptr <= ptr + 1'b1;
        if (!full) count <= count + 1'b1;
      end else if (do_pop) begin
        ptr   <= top_idx;
        count <= count - 1'b1;
      end
      je_q    <= (state_n == S_REDIRECT) || (state_n == S_FAULT_JUMP);
      flush_q <= (state_n == S_REDIRECT) || (state_n == S_FLUSH) || (state_n == S_FAULT_JUMP);
      rdy_q   <= (state_n == S_RUN);
      ja_q    <= jaddr_n;
      fault_q <= fault_n;
    end
  end

  // return-address storage; contents are meaningless after reset
  always_ff @(posedge clk) begin
    if (do_push) ras[ptr] <= bus.pc_in + 1'b1;
  end

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// tb/tb_pc_flow_ctrl.sv - directed and random bench for pc_flow_ctrl against a queue model
`timescale 1ns/1ps
module tb_pc_flow_ctrl;
  localparam int FLUSH = 2;
  localparam int DEPTH = 8;
  localparam logic [15:0] FV = 16'hFFF0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_flow_ctrl_if #(.WIDTH(16), .DEPTH(DEPTH)) bus ();

  pc_flow_ctrl #(.WIDTH(16), .DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH), .FAULT_VECTOR(FV)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;
  logic [15:0] ras_q[$];
  bit faulted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.pc_in = '0; bus.target = '0; bus.branch_req = 0; bus.cond_true = 0;
    bus.call_req = 0; bus.ret_req = 0; bus.stall_in = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    chk("rst_je", bus.jump_enable, 0);
    chk("rst_ja", bus.jump_address, 0);
    chk("rst_flush", bus.flush, 0);
    chk("rst_fault", bus.fault, 0);
    chk("rst_cnt", bus.ras_count, 0);
    chk("rst_rdy", bus.req_ready, 1);
    reset = 1'b0;
    ras_q.delete();
    faulted = 0;
  endtask

  task automatic expect_redirect(input logic [15:0] addr);
    chk("rd_je", bus.jump_enable, 1);
    chk("rd_ja", bus.jump_address, addr);
    chk("rd_flush", bus.flush, 1);
    chk("rd_rdy", bus.req_ready, 0);
    chk("rd_cnt", bus.ras_count, ras_q.size());
    for (int k = 0; k < FLUSH; k++) begin
      step();
      chk("fl_je", bus.jump_enable, 0);
      chk("fl_flush", bus.flush, 1);
      chk("fl_rdy", bus.req_ready, 0);
    end
    step();
    chk("back_rdy", bus.req_ready, 1);
    chk("back_flush", bus.flush, 0);
    chk("back_je", bus.jump_enable, 0);
  endtask

  task automatic expect_fault();
    chk("fj_je", bus.jump_enable, 1);
    chk("fj_ja", bus.jump_address, FV);
    chk("fj_flush", bus.flush, 1);
    chk("fj_fault", bus.fault, 1);
    chk("fj_rdy", bus.req_ready, 0);
    step();
    chk("fh_je", bus.jump_enable, 0);
    chk("fh_flush", bus.flush, 0);
    chk("fh_fault", bus.fault, 1);
    chk("fh_rdy", bus.req_ready, 0);
    chk("fh_cnt", bus.ras_count, ras_q.size());
    faulted = 1;
  endtask

  // one request for one cycle; the model decides what must happen
  task automatic issue(input bit r, input bit c, input bit b, input bit cond, input bit stall,
                       input logic [15:0] pc, input logic [15:0] tgt);
    int kind;
    logic [15:0] addr;
    bus.ret_req = r; bus.call_req = c; bus.branch_req = b; bus.cond_true = cond;
    bus.stall_in = stall; bus.pc_in = pc; bus.target = tgt;
    step();
    clear_inputs();
    kind = 0;
    addr = '0;
    if (faulted || stall) kind = 0;
    else if (r) begin
      if (ras_q.size() == 0) kind = 2;
      else begin addr = ras_q.pop_back(); kind = 1; end
    end else if (c) begin
      if (ras_q.size() == DEPTH) begin
`ifdef PC_FLOW_RAS_WRAP_EN
        void'(ras_q.pop_front());
        ras_q.push_back(16'(pc + 16'd1));
        addr = tgt; kind = 1;
`else
        kind = 2;
`endif
      end else begin
        ras_q.push_back(16'(pc + 16'd1));
        addr = tgt; kind = 1;
      end
    end else if (b && cond) begin
      addr = tgt; kind = 1;
    end
    case (kind)
      1: expect_redirect(addr);
      2: expect_fault();
      default: begin
        chk("q_je", bus.jump_enable, 0);
        chk("q_flush", bus.flush, 0);
        chk("q_rdy", bus.req_ready, !faulted);
        chk("q_fault", bus.fault, faulted);
        chk("q_cnt", bus.ras_count, ras_q.size());
      end
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    faulted = 0;
    do_reset();

    issue(0, 1, 0, 0, 0, 16'h0010, 16'h3333);
    issue(1, 0, 0, 0, 0, 16'h0000, 16'h0000);
    issue(0, 0, 1, 0, 0, 16'h0040, 16'h0100);
    issue(0, 0, 1, 1, 0, 16'h0040, 16'h0100);
    issue(0, 1, 0, 0, 0, 16'h0020, 16'h2000);
    issue(1, 1, 1, 1, 0, 16'h0050, 16'h5555);
    issue(0, 1, 0, 0, 1, 16'h0060, 16'h6666);
    issue(0, 1, 0, 0, 0, 16'hFFFF, 16'h7777);
    issue(1, 0, 0, 0, 0, 16'h0000, 16'h0000);

    for (int i = 0; i < DEPTH + 1; i++) issue(0, 1, 0, 0, 0, 16'(16 * i + 3), 16'(16'h4000 + i));
    issue(0, 0, 1, 1, 0, 16'h0001, 16'h0900);
    for (int i = 0; i < DEPTH + 1; i++) issue(1, 0, 0, 0, 0, 16'h0000, 16'h0000);
    issue(0, 1, 0, 0, 0, 16'h0001, 16'h0A00);
    #2;
    reset = 1'b1;
    #1;
    chk("hold_rst_fault", bus.fault, 0);
    chk("hold_rst_rdy", bus.req_ready, 1);
    do_reset();

    issue(1, 0, 0, 0, 0, 16'h0000, 16'h0000);
    do_reset();

    bus.call_req = 1; bus.pc_in = 16'h0100; bus.target = 16'h1234;
    step();
    clear_inputs();
    chk("mf_je", bus.jump_enable, 1);
    step();
    chk("mf_flush_pre", bus.flush, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mf_flush", bus.flush, 0);
    chk("mf_rdy", bus.req_ready, 1);
    chk("mf_cnt", bus.ras_count, 0);
    reset = 1'b0;
    ras_q.delete();
    faulted = 0;
    step();

    for (int n = 0; n < 300; n++) begin
      if (faulted) do_reset();
      issue($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
            16'($urandom), 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_flow_ctrl.md
Name: pc_flow_ctrl

Overview:
Control-flow sequencer in front of program_counter. Takes decoded branch/call/return requests from the decode stage, keeps a hardware return-address stack (RAS), and drives program_counter's jump_enable/jump_address. After every redirect it flushes the fetch/decode bubble for a fixed number of cycles. Stack overflow or underflow vectors the core to a fault handler.

Parameters:
WIDTH, 16, address width; matches counter_reg.
DEPTH, 8, RAS entries, power of two, minimum 2.
FLUSH_CYCLES, 2, bubble cycles after a redirect, 0..15.
FAULT_VECTOR, 16'hFFF0, jump target on a RAS fault.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high.
pc_in  in  WIDTH  current counter_reg of the requesting instruction.
target  in  WIDTH  branch/call destination from decode.
branch_req  in  1  conditional branch decoded.
cond_true  in  1  branch condition result; qualifies branch_req.
call_req  in  1  call decoded.
ret_req  in  1  return decoded.
stall_in  in  1  pipeline stall; requests are not sampled while high.
req_ready  out  1  high in RUN; requests accepted only when high.
jump_enable  out  1  one-cycle redirect strobe to program_counter.
jump_address  out  WIDTH  redirect target; valid while jump_enable is high.
flush  out  1  kill fetch/decode contents.
fault  out  1  sticky RAS fault indicator.
ras_count  out  $clog2(DEPTH)+1  current stack occupancy.

Behaviour:
- Reset (async): state=RUN, jump_enable=0, jump_address=0, flush=0, fault=0, ras_count=0. RAS contents are don't-care. Reset mid-flush or mid-fault returns to RUN on the same edge.
- Accept condition: state==RUN && !stall_in. Priority when several requests are high: ret_req > call_req > branch_req. A branch with cond_true=0 is a no-op; it is not a redirect and triggers no flush.
- States: RUN, REDIRECT, FLUSH, FAULT_JUMP, FAULT_HOLD. All outputs are registered.
- call accepted, stack not full: push pc_in+1 (mod 2^WIDTH, so 16'hFFFF+1 = 0), count+1, jump_address<=target, next state REDIRECT.
- ret accepted, stack not empty: pop top, count-1, jump_address<=popped value, next state REDIRECT.
- Taken branch accepted: jump_address<=target, next state REDIRECT. RAS unchanged.
- REDIRECT (exactly 1 cycle): jump_enable=1, flush=1, req_ready=0. Next state is FLUSH if FLUSH_CYCLES>0, else RUN.
- FLUSH: flush=1 for exactly FLUSH_CYCLES cycles (down-counter), jump_enable=0, requests ignored, then RUN. Total redirect latency: request edge to req_ready high again = 1+FLUSH_CYCLES cycles after the REDIRECT edge.
- Call on full (count==DEPTH): no push, fault<=1, jump_address<=FAULT_VECTOR, next state FAULT_JUMP.
- Ret on empty (count==0): same as call on full.
- FAULT_JUMP (1 cycle): jump_enable=1, flush=1. Next state FAULT_HOLD.
- FAULT_HOLD: jump_enable=0, flush=0, req_ready=0, fault=1. Held until reset; the block ignores all requests.
- stall_in is ignored outside RUN; the REDIRECT and FLUSH sequence is not extended by a stall.
- Push/pop happen only on an accepted request. There is no simultaneous push and pop.

Optional Feature:
PC_FLOW_RAS_WRAP_EN
- Defined: RAS is circular. A call on full overwrites the oldest entry, count saturates at DEPTH, and the block redirects normally with no fault. Ret on empty still faults.
- Undefined: call on full faults as described in Behaviour.

Test Plan:
- Reset, then pulse call_req with pc_in=16'h0010, target=16'h3333 -> next cycle jump_enable=1, jump_address=16'h3333, ras_count=1; flush high for 3 cycles total; req_ready high on the 4th cycle.
- Call from pc_in=16'h0010, then ret_req after the flush -> jump_enable=1, jump_address=16'h0011, ras_count=0.
- branch_req=1 with cond_true=0 -> no jump_enable, no flush, req_ready stays 1. Repeat with cond_true=1, target=16'h0100 -> redirect to 16'h0100.
- call_req and ret_req together with ras_count=1 -> ret wins (pop, count 0); call_req while stall_in=1 -> ignored. Call from pc_in=16'hFFFF, then ret -> returns to 16'h0000.
- 8 calls then a 9th -> macro off: jump_address=16'hFFF0, fault=1 sticky, later requests ignored, cleared only by reset asserted mid-FAULT_HOLD. Macro on: 9th redirects normally, ras_count stays 8, and the 8 rets return the 8 newest addresses.
- ret_req on empty -> FAULT_JUMP to 16'hFFF0 in both builds; asserting reset during FLUSH -> RUN, flush=0 immediately.
